lcd_receiver: RTL and testbench

- HD44780-compatible character-LCD responder. It decodes the write-only parallel bus (LCD_RS, LCD_E, LCD_D) driven by the board's LCD driver.
- Maintains an 80-byte DDRAM image plus display/cursor state.
- Exposes the DDRAM image through a read port so the simulator front end can render the 2x16 panel.
- Sits on the same clk as the driver; no R/W pin, no busy-flag readback on the bus.

---
 rtl/lcd_receiver.sv | 144 ++++++++++++++
 tb/tb_lcd_receiver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_receiver.sv
// HD44780-style character LCD responder: decodes RS/E/D writes into an 80-byte DDRAM image.
// rd_data has 1-cycle latency; no backpressure, bus events during the clear sequence are dropped with cmd_err.
module lcd_receiver #(
  parameter int         CLEAR_CYCLES = 80,
  parameter logic [7:0] BLANK        = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       LCD_RS,
  input  logic       LCD_E,
  input  logic [7:0] LCD_D,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       cmd_err
);

  localparam int DEPTH = 80;

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {SEL_DDRAM, SEL_CGRAM} ram_sel_t;

  state_t     state_q, state_d;
  ram_sel_t   ram_sel;
  logic       e_q;
  logic       increment;
  logic [6:0] clr_cnt;
  logic [7:0] ddram [DEPTH];

  logic ev, ev_ok, ev_drop, is_instr, is_ddram_data, ac_valid;
  logic data_wr, data_err, clear_done;

  function automatic logic addr_valid(input logic [6:0] a, input logic tl);
    return tl ? (a[5:0] <= 6'h27) : (a <= 7'h4F);
  endfunction

  // Two-line mode packs line 2 (0x40..0x67) directly after line 1 in the array.
  function automatic logic [6:0] addr_index(input logic [6:0] a, input logic tl);
    return tl ? ((a[6] ? 7'd40 : 7'd0) + {1'b0, a[5:0]}) : a;
  endfunction

  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic up, input logic tl);
    logic [6:0] n;
    if (tl && up && a == 7'h27)       n = 7'h40;
    else if (tl && up && a == 7'h67)  n = 7'h00;
    else if (tl && !up && a == 7'h00) n = 7'h67;
    else if (tl && !up && a == 7'h40) n = 7'h27;
    else if (!tl && up && a == 7'h4F) n = 7'h00;
    else if (!tl && !up && a == 7'h00) n = 7'h4F;
    else if (up)                      n = a + 7'd1;
    else                              n = a - 7'd1;
    return n;
  endfunction

  always_comb begin
    ev            = e_q & ~LCD_E;
    busy          = (state_q == CLEAR);
    ev_drop       = ev & busy;
    ev_ok         = ev & ~busy;
    is_instr      = ev_ok & ~LCD_RS;
    is_ddram_data = ev_ok & LCD_RS & (ram_sel == SEL_DDRAM);
    ac_valid      = addr_valid(cursor_addr, two_line);
    data_wr       = is_ddram_data & ac_valid;
    data_err      = is_ddram_data & ~ac_valid;
    clear_done    = busy & (clr_cnt == 7'(CLEAR_CYCLES - 1));
    state_d       = state_q;
    case (state_q)
      IDLE:    if (is_instr && LCD_D == 8'h01) state_d = CLEAR;
      CLEAR:   if (clear_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // The clear sequence owns the write port while busy; bus data is dropped then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (busy) begin
        if (clr_cnt < 7'(DEPTH)) ddram[clr_cnt] <= BLANK;
      end else if (data_wr) begin
        ddram[addr_index(cursor_addr, two_line)] <= LCD_D;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q         <= 1'b0;
      clr_cnt     <= 7'd0;
      cursor_addr <= 7'd0;
      increment   <= 1'b1;
      ram_sel     <= SEL_DDRAM;
      disp_on     <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      two_line    <= 1'b0;
      cmd_err     <= 1'b0;
      rd_data     <= BLANK;
    end else begin
      e_q     <= LCD_E;
      cmd_err <= ev_drop | data_err;
      clr_cnt <= (busy && !clear_done) ? clr_cnt + 7'd1 : 7'd0;
      rd_data <= addr_valid(rd_addr, two_line) ? ddram[addr_index(rd_addr, two_line)] : BLANK;

      if (clear_done) begin
        cursor_addr <= 7'd0;
        increment   <= 1'b1;
        ram_sel     <= SEL_DDRAM;
      end

      if (data_wr) cursor_addr <= addr_step(cursor_addr, increment, two_line);

      if (is_instr) begin
        priority casez (LCD_D)
          8'b1???????: begin
            cursor_addr <= LCD_D[6:0];
            ram_sel     <= SEL_DDRAM;
          end
          8'b01??????: ram_sel  <= SEL_CGRAM;
          8'b001?????: two_line <= LCD_D[3];
          8'b0001????: if (!LCD_D[3]) cursor_addr <= addr_step(cursor_addr, LCD_D[2], two_line);
          8'b00001???: begin
            disp_on   <= LCD_D[2];
            cursor_on <= LCD_D[1];
            blink_on  <= LCD_D[0];
          end
          8'b000001??: increment   <= LCD_D[1];
          8'b0000001?: cursor_addr <= 7'd0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_receiver.sv
// Randomised scoreboard bench for lcd_receiver against a panel-level reference model.
module tb_lcd_receiver;

  localparam logic [7:0] BLANK = 8'h20;
  localparam int         CLR   = 80;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       LCD_RS = 1'b0;
  logic       LCD_E = 1'b0;
  logic [7:0] LCD_D = 8'h00;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       disp_on, cursor_on, blink_on, two_line, busy, cmd_err;

  always #5 clk = ~clk;

  lcd_receiver #(.CLEAR_CYCLES(CLR), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .LCD_RS(LCD_RS), .LCD_E(LCD_E), .LCD_D(LCD_D),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .busy(busy), .cmd_err(cmd_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: panel contents as a flat 80-character array plus cursor/mode state.
  byte unsigned m_mem [80];
  int m_ac, m_inc, m_tl, m_cg, m_disp, m_cur, m_blink;
  int busy_start = -1000;

  typedef struct {
    int rd; int ac; int disp; int cur; int blink; int tl; int busy;
  } probe_t;
  probe_t probe_q [$];
  int     err_q [$];
  probe_t mon_p;
  logic   rd_req = 1'b0;
  logic   rd_pend = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic note_fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic int m_valid(input int a, input int tl);
    return tl != 0 ? int'((a % 64) < 40) : int'(a < 80);
  endfunction

  function automatic int m_index(input int a, input int tl);
    return tl != 0 ? ((a >= 64) ? 40 : 0) + (a % 64) : a;
  endfunction

  // Valid addresses walk the 80 panel cells circularly; others just count mod 128.
  function automatic int m_step(input int a, input int up, input int tl);
    int i;
    if (m_valid(a, tl) != 0) begin
      i = m_index(a, tl);
      i = (up != 0) ? (i + 1) % 80 : (i + 79) % 80;
      return (tl != 0) ? ((i < 40) ? i : 64 + i - 40) : i;
    end
    return (up != 0) ? (a + 1) % 128 : (a + 127) % 128;
  endfunction

  task automatic model_blank();
    for (int i = 0; i < 80; i++) m_mem[i] = BLANK;
  endtask

  task automatic model_reset(input int r);
    model_blank();
    m_ac = 0; m_inc = 1; m_tl = 0; m_cg = 0;
    m_disp = 0; m_cur = 0; m_blink = 0;
    busy_start = r;
  endtask

  task automatic model_event(input int t, input bit rs, input int d);
    if (t > busy_start && t <= busy_start + CLR) begin
      err_q.push_back(t);
    end else if (rs) begin
      if (m_cg == 0) begin
        if (m_valid(m_ac, m_tl) != 0) begin
          m_mem[m_index(m_ac, m_tl)] = 8'(d);
          m_ac = m_step(m_ac, m_inc, m_tl);
        end else begin
          err_q.push_back(t);
        end
      end
    end else if (d >= 128) begin
      m_ac = d % 128; m_cg = 0;
    end else if (d >= 64) begin
      m_cg = 1;
    end else if (d >= 32) begin
      m_tl = (d >> 3) & 1;
    end else if (d >= 16) begin
      if (((d >> 3) & 1) == 0) m_ac = m_step(m_ac, (d >> 2) & 1, m_tl);
    end else if (d >= 8) begin
      m_disp = (d >> 2) & 1; m_cur = (d >> 1) & 1; m_blink = d & 1;
    end else if (d >= 4) begin
      m_inc = (d >> 1) & 1;
    end else if (d >= 2) begin
      m_ac = 0;
    end else if (d == 1) begin
      busy_start = t;
      model_blank();
      m_ac = 0; m_inc = 1; m_cg = 0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    model_reset(cyc);
    reset = 1'b0;
  endtask

  task automatic bus_write(input bit rs, input int d, input int hi, input int lo);
    @(posedge clk); #1;
    LCD_RS = rs; LCD_D = d[7:0]; LCD_E = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    LCD_E = 1'b0;
    model_event(cyc + 1, rs, d);
    repeat (lo) @(posedge clk);
  endtask

  task automatic probe(input int a);
    probe_t p;
    @(posedge clk); #1;
    rd_addr = a[6:0];
    rd_req  = 1'b1;
    p.rd    = (m_valid(a, m_tl) != 0) ? int'(m_mem[m_index(a, m_tl)]) : int'(BLANK);
    p.ac    = m_ac; p.disp = m_disp; p.cur = m_cur; p.blink = m_blink; p.tl = m_tl;
    p.busy  = int'((cyc + 1 >= busy_start) && (cyc + 1 <= busy_start + CLR - 1));
    probe_q.push_back(p);
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) note_fail("busy_timeout");
  endtask

  task automatic busy_len();
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b1) n++;
      else break;
    end
    chk("busy_len", n, CLR);
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (probe_q.size() == 0) begin
        note_fail("probe_underflow");
      end else begin
        mon_p = probe_q.pop_front();
        chk("rd_data", rd_data, mon_p.rd);
        chk("cursor_addr", cursor_addr, mon_p.ac);
        chk("disp_on", disp_on, mon_p.disp);
        chk("cursor_on", cursor_on, mon_p.cur);
        chk("blink_on", blink_on, mon_p.blink);
        chk("two_line", two_line, mon_p.tl);
        chk("busy", busy, mon_p.busy);
      end
    end
    if (cmd_err !== 1'b0) begin
      if (err_q.size() == 0) note_fail("cmd_err_unexpected");
      else chk("cmd_err_cycle", cyc, err_q.pop_front());
    end else if (err_q.size() > 0 && err_q[0] < cyc) begin
      note_fail("cmd_err_missing");
      void'(err_q.pop_front());
    end
  end

  int init_seq [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  initial begin
    int op, d, hi, lo;
    bit rs;

    do_reset(3);
    busy_len();
    probe(7'h00); probe(7'h27); probe(7'h4F);

    foreach (init_seq[i]) begin
      bus_write(1'b0, init_seq[i], 25, 25);
      if (init_seq[i] == 1) wait_idle();
    end
    probe(7'h00);

    bus_write(1'b0, 8'h80, 3, 3);
    bus_write(1'b1, 8'h41, 3, 3);
    bus_write(1'b1, 8'h42, 3, 3);
    probe(7'h00); probe(7'h01);
    bus_write(1'b0, 8'hC0, 3, 3);
    bus_write(1'b1, 8'h33, 3, 3);
    probe(7'h40);

    bus_write(1'b0, 8'hA7, 3, 3);
    bus_write(1'b1, 8'h58, 3, 3);
    probe(7'h27);
    bus_write(1'b0, 8'h04, 3, 3);
    bus_write(1'b0, 8'h80, 3, 3);
    bus_write(1'b1, 8'h59, 3, 3);
    probe(7'h00);

    bus_write(1'b0, 8'h01, 3, 10);
    bus_write(1'b1, 8'h41, 3, 3);
    wait_idle();
    probe(7'h00);
    bus_write(1'b0, 8'hB0, 3, 3);
    bus_write(1'b1, 8'h41, 3, 3);
    probe(7'h30);

    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      hi = $urandom_range(1, 4);
      lo = $urandom_range(1, 4);
      rs = 1'b0;
      case (op)
        0, 1, 2, 3: begin rs = 1'b1; d = $urandom_range(32, 126); end
        4: begin
          if ($urandom_range(0, 3) == 0) d = 128 + $urandom_range(0, 127);
          else if ($urandom_range(0, 1) == 1) d = 128 + $urandom_range(0, 39);
          else d = 192 + $urandom_range(0, 39);
        end
        5: d = 4 + $urandom_range(0, 3);
        6: d = 16 + $urandom_range(0, 15);
        7: d = 2 + $urandom_range(0, 1);
        8: d = 32 + $urandom_range(0, 31);
        default: d = ($urandom_range(0, 1) == 1) ? 8 + $urandom_range(0, 7) : 64 + $urandom_range(0, 63);
      endcase
      bus_write(rs, d, hi, lo);
      if (k % 8 == 7) probe($urandom_range(0, 127));
    end

    bus_write(1'b0, 8'h01, 3, 3);
    wait_idle();
    bus_write(1'b0, 8'h38, 3, 3);
    bus_write(1'b0, 8'h06, 3, 3);
    bus_write(1'b0, 8'h85, 3, 3);
    bus_write(1'b1, 8'h5A, 1000, 5);
    probe(7'h05); probe(7'h06);

    @(posedge clk); #1;
    LCD_RS = 1'b1; LCD_D = 8'h7E; LCD_E = 1'b1;
    repeat (20) @(posedge clk);
    do_reset(3);
    repeat (10) @(posedge clk);
    #1;
    LCD_E = 1'b0;
    model_event(cyc + 1, 1'b1, 8'h7E);
    repeat (5) @(posedge clk);
    wait_idle();
    probe(7'h06); probe(7'h05);

    bus_write(1'b0, 8'h01, 3, 3);
    repeat (30) @(posedge clk);
    do_reset(2);
    busy_len();
    probe(7'h00);

    repeat (5) @(posedge clk);
    chk("err_q_drained", err_q.size(), 0);
    chk("probe_q_drained", probe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
